imem_loader: RTL and testbench
==============================

# imem_loader

Write-side master for `instruction_memory`. Receives a program as a byte stream, packs bytes into 32-bit little-endian words and drives the memory's `wr`/`addr`/`wdata` port one word per write. Holds the RISC-V core in reset until the load completes. Replaces testbench-driven filling with a synthesizable boot path.

## Interface
- `WIDTH1`, 32: word width; must match `instruction_memory`.
- `MEM_SIZE`, 1024: memory depth in words.
- `BASE_ADDR`, 0: byte address of the first word written; word aligned.

Ports (clock and reset first):
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request to begin a load.
- `in_valid` input 1: byte-stream valid.
- `in_data` input 8: byte-stream data.
- `in_ready` output 1: loader accepts a byte when `in_valid && in_ready` at a clock edge.
- `imem_wr` output 1: drives memory `wr`.
- `imem_addr` output WIDTH1: drives memory `addr`, byte address.
- `imem_wdata` output WIDTH1: drives memory `wdata`.
- `busy` output 1: load in progress.
- `done` output 1: sticky load-complete flag.
- `overflow` output 1: sticky; the stream contained words beyond memory capacity.
- `core_reset` output 1: holds the core in reset while high.

## Operation
- Stream format: 2-byte word count N, LSB first, then N words of 4 bytes each, LSB first.
- FSM states:
  - IDLE: `start` goes to LEN_LO and clears `done` and `overflow`.
  - LEN_LO: accepts byte 0 of N.
  - LEN_HI: accepts byte 1 of N. Goes to DONE if N==0, else to DATA.
  - DATA: accepts 4 bytes into the pack register, then goes to WRITE.
  - WRITE: one cycle. `imem_wr`=1 if word index < MEM_SIZE; otherwise `imem_wr` stays 0 and `overflow` is set. Next, word index increments and `imem_addr` advances by 4. Goes to DATA if words remain, else DONE.
  - DONE: `done`=1 and `core_reset`=0. `start` re-enters LEN_LO.
- `in_ready`=1 only in LEN_LO, LEN_HI and DATA. It is 0 in IDLE, WRITE and DONE.
- `busy`=1 in LEN_LO, LEN_HI, DATA and WRITE.
- `core_reset`=1 from reset until DONE is entered. It returns to 1 on restart.
- Memory write is level-sensitive, so `imem_addr` and `imem_wdata` change only while `imem_wr`=0. Both are stable the cycle before, during and after the write pulse.
- Word index is 16 bits. Address arithmetic is `BASE_ADDR + 4*index`, truncated to WIDTH1.
- Overflow words are consumed from the stream and dropped. The load still terminates normally in DONE.
- `start` outside IDLE/DONE is ignored.
- Reset mid-load:
  - returns to IDLE and deasserts `imem_wr` in the same edge;
  - sets `core_reset`=1;
  - discards any partially packed word; words already written remain in memory.

## Timing
- Reset values: `imem_wr`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `in_ready`=0, `busy`=0, `done`=0, `overflow`=0, `core_reset`=1.
- All outputs are registered, or decoded directly from the state register.
- `start` at edge k: `in_ready`=1 and `busy`=1 in cycle k+1.
- 4th byte of a word accepted at edge k: `imem_wdata` valid in cycle k+1, `imem_wr`=1 in cycle k+1. `imem_addr` advances at edge k+2.
- Peak throughput: 4 bytes per 5 cycles.
- Gaps in `in_valid` stall the FSM in place with no state loss.
- N words with no stream gaps: DONE is reached 2 + 5N cycles after the first accepted byte.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE);
  - `LEN_BYTES`=2, `BYTES_PER_WORD`=4.
- Sub-module `byte_packer`: 2-bit byte counter plus 32-bit shift/insert register.
  - Inputs: `load_en`, `byte_in`, `clear`.
  - Outputs: `word_out`, `word_full`.
  - Instantiated once. The FSM, address counter and flags live in the top.

## Test plan
- **Normal load:** N=2, words 0x00100093, 0x00200113, with `instruction_memory` attached → exactly two `imem_wr` pulses:
  - addr 0x0 with 0x00100093;
  - addr 0x4 with 0x00200113.
  - Then `done`=1, `core_reset`=0; memory readback matches.
- **Empty load:** N=0 → DONE two accepted bytes after `start`, no `imem_wr` pulse, `overflow`=0.
- **Backpressure:** `in_valid` toggling randomly on a 3-word load → identical memory contents. `in_ready`=0 during every WRITE cycle; no byte is lost or duplicated.
- **Capacity overflow:** MEM_SIZE=4, N=6 → 4 writes at 0x0–0xC, all 24 data bytes consumed, `overflow`=1, `done`=1.
- **Reset mid-load:** `reset` during the 3rd byte of word 1 → next cycle state IDLE, `imem_wr`=0, `core_reset`=1, `busy`=0. A subsequent full load succeeds.
- **Stray start:** `start` asserted during DATA → ignored, load completes unchanged. `start` in DONE → `done` clears and a second load proceeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_full flags the byte
// that completes a word, so the packed word is visible the cycle after it.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [1:0] cnt;

  assign word_full = load_en && (cnt == 2'(BYTES_PER_WORD - 1));

  // Shift in from the top: after four bytes the first one sits in [7:0].
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt      <= 2'd0;
      word_out <= 32'd0;
    end else if (load_en) begin
      cnt      <= cnt + 2'd1;
      word_out <= {byte_in, word_out[31:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed program into instruction_memory and
// holds the core in reset until the load has completed.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_LO | accepting low byte of the word count
// LEN_HI | accepting high byte of the word count
// DATA   | accepting the four bytes of the current word
// WRITE  | one-cycle write pulse (suppressed past capacity)
// DONE   | load complete, core released, waiting for restart
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH1    = 32,
  parameter int MEM_SIZE  = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr,
  output logic [WIDTH1-1:0] imem_addr,
  output logic [WIDTH1-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              core_reset
);

  state_t            state;
  logic [15:0]       n_words;
  logic [15:0]       idx;
  logic              adv_pending;
  logic              in_range;
  logic              start_ok;
  logic              pack_load;
  logic              pack_full;
  logic [31:0]       pack_word;
  logic [WIDTH1-1:0] addr_of_idx;

  assign in_ready   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign busy       = in_ready || (state == WRITE);
  assign done       = (state == DONE);
  assign core_reset = (state != DONE);

  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign pack_load   = in_valid && (state == DATA);
  assign in_range    = (32'(idx) < 32'(MEM_SIZE));
  assign addr_of_idx = WIDTH1'(BASE_ADDR) + WIDTH1'({idx, 2'b00});
  assign imem_wdata  = WIDTH1'(pack_word);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .load_en   (pack_load),
    .clear     (start_ok),
    .byte_in   (in_data),
    .word_out  (pack_word),
    .word_full (pack_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      imem_wr     <= 1'b0;
      imem_addr   <= WIDTH1'(BASE_ADDR);
      overflow    <= 1'b0;
      n_words     <= 16'd0;
      idx         <= 16'd0;
      adv_pending <= 1'b0;
    end else begin
      imem_wr     <= 1'b0;
      adv_pending <= 1'b0;
      // Address moves one cycle after the pulse so it brackets the write.
      if (adv_pending)
        imem_addr <= addr_of_idx;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LEN_LO;
            overflow  <= 1'b0;
            idx       <= 16'd0;
            imem_addr <= WIDTH1'(BASE_ADDR);
          end
        end
        LEN_LO: begin
          if (in_valid) begin
            n_words[7:0] <= in_data;
            state        <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (in_valid) begin
            n_words[15:8] <= in_data;
            state         <= ({in_data, n_words[7:0]} == 16'd0) ? DONE : DATA;
          end
        end
        DATA: begin
          if (pack_full) begin
            state   <= WRITE;
            imem_wr <= in_range;
          end
        end
        WRITE: begin
          if (!in_range)
            overflow <= 1'b1;
          idx         <= idx + 16'd1;
          adv_pending <= 1'b1;
          state       <= (16'(idx + 16'd1) == n_words) ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader with a 4-word memory model attached.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_wr;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        core_reset;

  always #5 clk = ~clk;

  imem_loader #(.WIDTH1(32), .MEM_SIZE(4), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_wr    (imem_wr),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .core_reset (core_reset)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem     [0:3];
  logic [31:0] exp_mem [0:3];
  logic [31:0] prog    [0:7];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          wr_count = 0;
  logic        prev_wr  = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_wr && imem_addr < 32'd16)
      mem[imem_addr[3:2]] <= imem_wdata;
  end

  // Monitor: every write pulse is matched against the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (prev_wr)
      check("addr_hold_after_wr", imem_addr, prev_addr);
    if (imem_wr) begin
      wr_count++;
      check("in_ready_during_write", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e.addr);
        check("write_data", imem_wdata, e.data);
      end
    end
    prev_wr   <= imem_wr;
    prev_addr <= imem_addr;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL byte_accept: byte 0x%02h not accepted, required acceptance within 50 cycles", b);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done_clr", {31'd0, done}, 32'd0);
    check("start_ovf_clr", {31'd0, overflow}, 32'd0);
    check("start_core_reset", {31'd0, core_reset}, 32'd1);
  endtask

  task automatic wait_done(output int at_cyc);
    bit ok = 0;
    at_cyc = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        at_cyc = cyc;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: done=0 after 200 cycles, required 1");
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < 4; i++)
      check("mem_readback", mem[i], exp_mem[i]);
  endtask

  // n words from prog[]; gaps randomises in_valid; stray pulses start inside DATA.
  task automatic run_load(input int n, input bit gaps, input bit stray, input bit exp_ovf);
    int first, at, wr0;
    logic [31:0] nn;
    wr_t e;
    nn  = 32'(n);
    wr0 = wr_count;
    do_start();
    for (int w = 0; w < n; w++) begin
      if (w < 4) begin
        e.addr = 32'(4 * w);
        e.data = prog[w];
        exp_q.push_back(e);
        exp_mem[w] = prog[w];
      end
    end
    send_byte(nn[7:0], 0);
    first = cyc;
    send_byte(nn[15:8], gaps ? int'($urandom_range(0, 2)) : 0);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (stray && w == 0 && b == 2) begin
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
          check("stray_start_busy", {31'd0, busy}, 32'd1);
          check("stray_start_done", {31'd0, done}, 32'd0);
        end
        send_byte(prog[w][8*b +: 8], gaps ? int'($urandom_range(0, 2)) : 0);
      end
    end
    wait_done(at);
    if (!gaps && !stray)
      check("done_latency_edges", 32'(at - first), 32'(1 + 5 * n));
    #1;
    check("done_flag", {31'd0, done}, 32'd1);
    check("done_core_reset", {31'd0, core_reset}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    check("done_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    @(negedge clk);
    check("write_count", 32'(wr_count - wr0), 32'(n < 4 ? n : 4));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check_mem();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_imem_wr", {31'd0, imem_wr}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    @(posedge clk);
    #1;

    // Normal two-word load
    prog[0] = 32'h00100093;
    prog[1] = 32'h00200113;
    run_load(2, 0, 0, 0);

    // Empty load, started from DONE
    run_load(0, 0, 0, 0);

    // Backpressure on three words
    prog[0] = 32'hDEADBEEF;
    prog[1] = 32'h01234567;
    prog[2] = 32'hA5C3_0F81;
    run_load(3, 1, 0, 0);

    // Capacity overflow: six words into a four-word memory
    for (int i = 0; i < 6; i++)
      prog[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
    run_load(6, 0, 0, 1);

    // Reset during third byte of word 1
    prog[0] = 32'hCAFEF00D;
    prog[1] = 32'h87654321;
    do_start();
    e.addr = 32'd0;
    e.data = prog[0];
    exp_q.push_back(e);
    exp_mem[0] = prog[0];
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 4; b++)
      send_byte(prog[0][8*b +: 8], 0);
    send_byte(prog[1][7:0], 0);
    send_byte(prog[1][15:8], 0);
    in_valid = 1'b1;
    in_data  = prog[1][23:16];
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_core_reset", {31'd0, core_reset}, 32'd1);
    check("midrst_imem_wr", {31'd0, imem_wr}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_scoreboard", 32'(exp_q.size()), 32'd0);
    check_mem();

    prog[0] = 32'h0000_0013;
    prog[1] = 32'hFFFF_FFFF;
    run_load(2, 0, 0, 0);

    // Stray start inside DATA, then restart from DONE
    prog[0] = 32'h1122_3344;
    prog[1] = 32'h5566_7788;
    prog[2] = 32'h99AA_BBCC;
    run_load(3, 0, 1, 0);
    run_load(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
